// File: rtl/adc_temp_bcd_if.sv
// adc_temp_bcd_if: sample channel carrying raw ADC codes into adc_temp_bcd.
//   sample_valid  producer -> block : sample is present
//   sample        producer -> block : raw unsigned ADC code
//   sample_ready  block -> producer : block takes the sample on this edge
// The producer holds sample_valid/sample steady while sample_ready is low.
interface adc_temp_bcd_if #(
    parameter int ADC_W = 12
);
    logic             sample_valid;
    logic [ADC_W-1:0] sample;
    logic             sample_ready;

    modport master (output sample_valid, output sample, input  sample_ready);
    modport slave  (input  sample_valid, input  sample, output sample_ready);
endinterface

// File: rtl/adc_temp_bcd.sv
// adc_temp_bcd: averages 2**AVG_LOG2 ADC samples, scales the average to
// degrees, saturates to DIGITS decimal digits and converts it to BCD with a
// bit-serial double-dabble. Each finished result is presented with a
// one-cycle bcd_valid_o strobe.
// Ports:
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   s_if          sample channel (valid/ready), slave side
//   clear_i       synchronous abort/restart of averaging and conversion
//   bcd_out_o     result digits, [3:0] = least-significant digit
//   bcd_valid_o   one-cycle strobe; bcd_out_o/overflow_o just updated
//   overflow_o    last result was clamped to 10**DIGITS-1
//   busy_o        high while a result is being computed (SCALE/CONVERT/DONE)
module adc_temp_bcd #(
    parameter int ADC_W       = 12,
    parameter int AVG_LOG2    = 2,
    parameter int SCALE_MUL   = 5,
    parameter int SCALE_SHIFT = 3,
    parameter int DIGITS      = 4
) (
    input  logic                clk,
    input  logic                rst,
    adc_temp_bcd_if.slave       s_if,
    input  logic                clear_i,
    output logic [4*DIGITS-1:0] bcd_out_o,
    output logic                bcd_valid_o,
    output logic                overflow_o,
    output logic                busy_o
);
    localparam int BIN_W = ADC_W + 8;
    localparam int BCD_W = 4 * DIGITS;
    localparam int ACC_W = ADC_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int BIT_W = $clog2(BIN_W + 1);
    localparam int NSAMP = 2 ** AVG_LOG2;
    localparam logic [BIN_W-1:0] MAXV = BIN_W'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {ACCUM, SCALE, CONVERT, DONE} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0]   bcd_out_q, bcd_out_d;
    logic               ovf_q, ovf_d;
    logic               bcd_valid_q, bcd_valid_d;

    logic               ready;
    logic               accept;
    logic [ADC_W-1:0]   avg;
    logic [BIN_W-1:0]   prod;
    logic [BIN_W-1:0]   scaled;
    logic [BCD_W-1:0]   adj;

    assign ready             = (state_q == ACCUM) && !clear_i;
    assign accept            = s_if.sample_valid && ready;
    assign s_if.sample_ready = ready;
    assign busy_o            = (state_q != ACCUM);
    assign bcd_out_o         = bcd_out_q;
    assign overflow_o        = ovf_q;
    assign bcd_valid_o       = bcd_valid_q;

    // Truncating average; the product cannot exceed BIN_W bits as SCALE_MUL <= 255.
    assign avg    = acc_q[ACC_W-1:AVG_LOG2];
    assign prod   = BIN_W'(avg) * BIN_W'(SCALE_MUL);
    assign scaled = prod >> SCALE_SHIFT;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift so it
    // carries correctly into the next decimal digit.
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        bin_d       = bin_q;
        bcd_d       = bcd_q;
        bit_d       = bit_q;
        ovf_pend_d  = ovf_pend_q;
        bcd_out_d   = bcd_out_q;
        ovf_d       = ovf_q;
        bcd_valid_d = 1'b0;

        case (state_q)
            ACCUM: begin
                if (accept) begin
                    acc_d   = acc_q + ACC_W'(s_if.sample);
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(NSAMP - 1))
                        state_d = SCALE;
                end
            end
            SCALE: begin
                if (scaled > MAXV) begin
                    bin_d      = MAXV;
                    ovf_pend_d = 1'b1;
                end else begin
                    bin_d      = scaled;
                    ovf_pend_d = 1'b0;
                end
                bcd_d   = '0;
                bit_d   = '0;
                state_d = CONVERT;
            end
            CONVERT: begin
                {bcd_d, bin_d} = {adj[BCD_W-2:0], bin_q, 1'b0};
                bit_d          = bit_q + BIT_W'(1);
                if (bit_q == BIT_W'(BIN_W - 1))
                    state_d = DONE;
            end
            DONE: begin
                bcd_out_d   = bcd_q;
                ovf_d       = ovf_pend_q;
                bcd_valid_d = 1'b1;
                acc_d       = '0;
                count_d     = '0;
                state_d     = ACCUM;
            end
            default: state_d = ACCUM;
        endcase

        // Clear aborts everything in flight; a result already in DONE is
        // still delivered because its update was set up above.
        if (clear_i) begin
            state_d = ACCUM;
            acc_d   = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            bin_q       <= '0;
            bcd_q       <= '0;
            bit_q       <= '0;
            ovf_pend_q  <= 1'b0;
            bcd_out_q   <= '0;
            ovf_q       <= 1'b0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            bin_q       <= bin_d;
            bcd_q       <= bcd_d;
            bit_q       <= bit_d;
            ovf_pend_q  <= ovf_pend_d;
            bcd_out_q   <= bcd_out_d;
            ovf_q       <= ovf_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end
endmodule
